rob_commit_unit: RTL
====================

Name: rob_commit_unit

Overview:
- Reorder buffer that sits directly downstream of the reservation-station writeback stage of the Tomasulo core.
- Allocates one in-order entry per issued instruction and captures results broadcast on the common data bus (CDB).
- Retires entries strictly in program order to the architectural register file, at most one per cycle.
- On commit of a mispredicted BEQ, pulses a flush and discards all younger entries.

Parameters:
- DEPTH, 8, number of ROB entries; must be a power of two.
- TAG_W, 3, entry tag width; equals log2(DEPTH).
- DATA_W, 16, result and register data width.

Ports:
- clk  input  1  clock
- reset  input  1  reset; synchronous, active-high
- alloc_valid  input  1  issue stage requests an entry
- alloc_ready  output  1  entry available; combinational
- alloc_opcode  input  5  0=LOAD 1=STORE 2=ADD 3=MUL 4=BEQ
- alloc_dest  input  3  destination architectural register
- alloc_tag  output  TAG_W  tag assigned to this allocation; equals tail pointer; combinational
- cdb_valid  input  1  result broadcast valid
- cdb_tag  input  TAG_W  ROB tag of the broadcast result
- cdb_value  input  DATA_W  result value
- cdb_mispredict  input  1  on a BEQ broadcast: branch was taken, so the not-taken prediction was wrong
- qry_tag  input  TAG_W  operand lookup tag
- qry_ready  output  1  entry qry_tag is valid and done; combinational
- qry_value  output  DATA_W  value of entry qry_tag; combinational
- commit_valid  output  1  one-cycle retire pulse; registered
- commit_we  output  1  retire writes a register; registered
- commit_dest  output  3  register written; registered
- commit_value  output  DATA_W  value written; registered
- flush  output  1  one-cycle pipeline flush pulse; registered
- count  output  TAG_W+1  number of occupied entries
- retired_total  output  32  instructions retired since reset
- flush_total  output  16  flushes since reset

Behaviour:
- Storage: circular buffer with head, tail and count. Each entry holds valid, done, opcode, dest, value and mispred.
- alloc_ready = (count < DEPTH) and not flush_pending.
  - flush_pending means the head entry is a valid, done BEQ with mispred=1.
  - There is no same-cycle bypass: a full ROB refuses allocation even if a commit occurs on that edge.
- Allocate on an edge where alloc_valid && alloc_ready:
  - entry[tail] gets valid=1, done=0, opcode, dest, mispred=0.
  - tail advances by 1, wrapping from DEPTH-1 to 0.
- CDB capture on an edge where cdb_valid is high and entry[cdb_tag] is valid:
  - set done=1, value=cdb_value, mispred=cdb_mispredict.
  - A CDB write to an invalid entry is ignored.
  - A CDB write to an already-done entry overwrites it (last write wins).
- Commit on each edge where entry[head] is valid and done, judged on state before the edge:
  - next cycle: commit_valid=1, commit_dest=dest, commit_value=value.
  - commit_we=1 only for LOAD, ADD or MUL with dest != 0. R0 is never written.
  - STORE, BEQ and unknown opcodes retire with commit_we=0.
  - entry is cleared, head advances with wrap, retired_total increments.
  - In cycles with no commit, commit_valid, commit_we and flush are 0.
- Latency: a CDB result for the head entry sampled at edge E appears as commit_valid during the cycle after edge E+1. One entry retires per cycle thereafter.
- Flush: when the retiring entry is a BEQ with mispred=1, on the same edge:
  - commit_valid=1, commit_we=0, flush=1 for one cycle.
  - all entries invalidated; head=tail=count=0; flush_total increments.
  - a simultaneous CDB write is discarded; allocation is already blocked by flush_pending.
- count update per edge: +1 on alloc, -1 on commit, both on the same edge leaves it unchanged; forced to 0 on flush.
- Query port: qry_ready and qry_value reflect registered state only, with no CDB bypass. qry_value is 0 when qry_ready=0.
- Reset, at any time including mid-operation:
  - head, tail, count, retired_total and flush_total go to 0; all entries invalid.
  - commit_valid, commit_we, commit_dest, commit_value and flush go to 0.
  - alloc_ready is 1 in the first cycle after reset.

Test Plan:
- Reset, then allocate ADD dest=3 and get tag 0; CDB tag0 value 0x0012 -> one cycle later commit_valid=1, commit_we=1, commit_dest=3, commit_value=0x0012; count returns 0.
- Allocate MUL d1 (tag0) then ADD d2 (tag1); CDB tag1=5 first, then tag0=7 two cycles later -> no commit until tag0 is done, then commits tag0=7 and tag1=5 on consecutive cycles, in order.
- Allocate 8 entries -> count=8 and alloc_ready=0; a 9th alloc_valid is ignored; complete tag0 -> after its commit alloc_ready=1, and the next allocation gets tag 0 (wrap).
- Allocate BEQ (tag0), ADD d4 (tag1), LOAD d5 (tag2); CDB tag1, then tag0 with cdb_mispredict=1 -> commit_valid=1, commit_we=0, flush=1 for one cycle; count=0, flush_total=1; ADD is never committed; next alloc_tag=0.
- STORE d2 and ADD d0 both completed -> both retire with commit_we=0; retired_total increments by 2.
- Allocate 3 entries, CDB tag0, then assert reset on the next edge -> commit_valid stays 0, count=0, retired_total=0.

Source files
------------

// File: rtl/rob_commit_unit_if.sv
// Reorder buffer port bundle: allocation, CDB capture, operand query,
// retire stream and status counters.
interface rob_commit_unit_if #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [4:0]        alloc_opcode;
  logic [2:0]        alloc_dest;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              cdb_mispredict;
  logic [TAG_W-1:0]  qry_tag;
  logic              qry_ready;
  logic [DATA_W-1:0] qry_value;
  logic              commit_valid;
  logic              commit_we;
  logic [2:0]        commit_dest;
  logic [DATA_W-1:0] commit_value;
  logic              flush;
  logic [TAG_W:0]    count;
  logic [31:0]       retired_total;
  logic [15:0]       flush_total;

  modport slave (
    input  alloc_valid, alloc_opcode, alloc_dest,
    input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict,
    input  qry_tag,
    output alloc_ready, alloc_tag, qry_ready, qry_value,
    output commit_valid, commit_we, commit_dest, commit_value,
    output flush, count, retired_total, flush_total
  );

  modport master (
    output alloc_valid, alloc_opcode, alloc_dest,
    output cdb_valid, cdb_tag, cdb_value, cdb_mispredict,
    output qry_tag,
    input  alloc_ready, alloc_tag, qry_ready, qry_value,
    input  commit_valid, commit_we, commit_dest, commit_value,
    input  flush, count, retired_total, flush_total
  );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: allocates at tail, captures CDB results,
// retires one entry per cycle from head, flushes on mispredicted BEQ.
module rob_commit_unit #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16
) (
  input logic              clk,
  input logic              reset,
  rob_commit_unit_if.slave rob
);
  localparam logic [4:0] OP_LOAD = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_MUL  = 5'd3;
  localparam logic [4:0] OP_BEQ  = 5'd4;
  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  mis_q, mis_d;
  logic [4:0]        op_q  [DEPTH];
  logic [4:0]        op_d  [DEPTH];
  logic [2:0]        dst_q [DEPTH];
  logic [2:0]        dst_d [DEPTH];
  logic [DATA_W-1:0] val_q [DEPTH];
  logic [DATA_W-1:0] val_d [DEPTH];

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic              cv_q, cv_d;
  logic              cwe_q, cwe_d;
  logic [2:0]        cdst_q, cdst_d;
  logic [DATA_W-1:0] cval_q, cval_d;
  logic              flush_q, flush_d;
  logic [31:0]       ret_q, ret_d;
  logic [15:0]       fl_q, fl_d;

  logic [4:0]        hd_op;
  logic [2:0]        hd_dst;
  logic [DATA_W-1:0] hd_val;
  logic              do_commit;
  logic              do_flush;
  logic              do_alloc;
  logic              wr_op;
  logic              qry_hit;

  assign hd_op  = op_q[head_q];
  assign hd_dst = dst_q[head_q];
  assign hd_val = val_q[head_q];

  assign do_commit = valid_q[head_q] & done_q[head_q];
  assign do_flush  = do_commit & mis_q[head_q]
                   & (hd_op == OP_BEQ);
  assign do_alloc  = rob.alloc_valid & rob.alloc_ready;

  always_comb begin
    unique case (1'b1)
      hd_op == OP_LOAD,
      hd_op == OP_ADD,
      hd_op == OP_MUL: wr_op = 1'b1;
      default:         wr_op = 1'b0;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    mis_d   = mis_q;
    op_d    = op_q;
    dst_d   = dst_q;
    val_d   = val_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cv_d    = do_commit;
    cwe_d   = do_commit & wr_op & (hd_dst != 3'd0);
    cdst_d  = cdst_q;
    cval_d  = cval_q;
    flush_d = do_flush;
    ret_d   = ret_q;
    fl_d    = fl_q;

    if (rob.cdb_valid && valid_q[rob.cdb_tag]) begin
      done_d[rob.cdb_tag] = 1'b1;
      val_d[rob.cdb_tag]  = rob.cdb_value;
      mis_d[rob.cdb_tag]  = rob.cdb_mispredict;
    end

    // Retire clears after capture so a late CDB hit cannot revive it
    if (do_commit) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      mis_d[head_q]   = 1'b0;
      head_d = head_q + 1'b1;
      cdst_d = hd_dst;
      cval_d = hd_val;
      ret_d  = ret_q + 32'd1;
    end

    if (do_alloc) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      mis_d[tail_q]   = 1'b0;
      op_d[tail_q]    = rob.alloc_opcode;
      dst_d[tail_q]   = rob.alloc_dest;
      tail_d = tail_q + 1'b1;
    end

    if (do_alloc && !do_commit)
      count_d = count_q + 1'b1;
    else if (do_commit && !do_alloc)
      count_d = count_q - 1'b1;

    if (do_flush) begin
      valid_d = '0;
      done_d  = '0;
      mis_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      fl_d    = fl_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      done_q  <= '0;
      mis_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cv_q    <= 1'b0;
      cwe_q   <= 1'b0;
      cdst_q  <= '0;
      cval_q  <= '0;
      flush_q <= 1'b0;
      ret_q   <= '0;
      fl_q    <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cv_q    <= cv_d;
      cwe_q   <= cwe_d;
      cdst_q  <= cdst_d;
      cval_q  <= cval_d;
      flush_q <= flush_d;
      ret_q   <= ret_d;
      fl_q    <= fl_d;
    end
  end

  // Payload is qualified by valid/done, so it needs no reset
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    dst_q <= dst_d;
    val_q <= val_d;
  end

  assign qry_hit = valid_q[rob.qry_tag] & done_q[rob.qry_tag];

  assign rob.alloc_ready   = (count_q < FULL) & ~do_flush;
  assign rob.alloc_tag     = tail_q;
  assign rob.qry_ready     = qry_hit;
  assign rob.qry_value     = qry_hit ? val_q[rob.qry_tag] : '0;
  assign rob.commit_valid  = cv_q;
  assign rob.commit_we     = cwe_q;
  assign rob.commit_dest   = cdst_q;
  assign rob.commit_value  = cval_q;
  assign rob.flush         = flush_q;
  assign rob.count         = count_q;
  assign rob.retired_total = ret_q;
  assign rob.flush_total   = fl_q;
endmodule
